azadi_pad_arbiter: RTL and testbench
====================================

# azadi_pad_arbiter

Per-pad ownership arbiter that time-shares a group of SoC IO pads between the GPIO controller and one alternate peripheral function per pad (SPI slave-selects, PWM outputs). It sits between the peripherals in `azadi_soc_top` and the `io_in/io_out/io_oeb` pads of the Caravel wrapper. Ownership changes go through a request/grant handshake with a programmable bus-turnaround gap during which the pad is tristated. Optional Wishbone registers lock pads to GPIO and set the gap length.

## Interface
- `NPADS`, 8: number of arbitrated pads (1..16).
- `TURN_CYCLES`, 2: default turnaround length in cycles (1..15).

Ports:
- `wb_clk_i`  in  1  Single clock.
- `wb_rst_i`  in  1  Reset, synchronous and active-high.
- `alt_req_i`  in  NPADS  Alternate function requests pad ownership, level.
- `alt_gnt_o`  out  NPADS  Alternate function owns the pad, registered.
- `alt_o`, `alt_oe_i`  in  NPADS each  Alternate function output and output enable (active-high).
- `gpio_o_i`, `gpio_oe_i`  in  NPADS each  GPIO output and output enable (active-high).
- `pad_in_i`  in  NPADS  Pad input.
- `pad_out_o`  out  NPADS  Pad output.
- `pad_oeb_o`  out  NPADS  Pad output enable, active-low.
- `gpio_i_o`  out  NPADS  Pad input routed to GPIO; always equals `pad_in_i`.
- `alt_i_o`  out  NPADS  Pad input routed to the alternate function; `pad_in_i & alt_gnt_o`.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone slave control. Present only with `PAD_ARB_WB_EN`.
- `wbs_sel_i`  in  4  Byte selects. Present only with `PAD_ARB_WB_EN`.
- `wbs_adr_i`  in  32  Address; bits [3:2] decode the register. Present only with `PAD_ARB_WB_EN`.
- `wbs_dat_i`  in  32  Write data. Present only with `PAD_ARB_WB_EN`.
- `wbs_ack_o`  out  1  Ack. Present only with `PAD_ARB_WB_EN`.
- `wbs_dat_o`  out  32  Read data. Present only with `PAD_ARB_WB_EN`.

## Operation
- Each pad has an independent FSM (GPIO, TURN_A, ALT, TURN_G) and a 4-bit turnaround counter.
- GPIO state:
  - `pad_out_o = gpio_o_i`, `pad_oeb_o = ~gpio_oe_i`.
  - Goes to TURN_A when `alt_req_i` is high and the pad's LOCK bit is 0. The counter loads TURN.
- TURN_A:
  - `pad_out_o = 0`, `pad_oeb_o = 1`, `alt_gnt_o = 0`.
  - The counter decrements each cycle. When it reaches 1, goes to ALT.
  - If `alt_req_i` drops or LOCK becomes set, returns to GPIO on the next edge (abort).
- ALT state:
  - `pad_out_o = alt_o`, `pad_oeb_o = ~alt_oe_i`, `alt_gnt_o = 1`.
  - Goes to TURN_G when `alt_req_i` falls or LOCK is set. The counter loads TURN.
- TURN_G:
  - Pad tristated, `alt_gnt_o = 0`. Counts down TURN cycles, then goes to GPIO.
  - A new request during TURN_G is ignored until GPIO is reached.
- `pad_out_o`, `pad_oeb_o`, `gpio_i_o` and `alt_i_o` are combinational from the state register and inputs.
- `alt_gnt_o` is a registered state decode.
- TURN value 0 is treated as 1.
- Registers, implemented only with `PAD_ARB_WB_EN`:
  - 0x0 LOCK: RW, bits [NPADS-1:0], reset 0.
  - 0x4 STATUS: RO. `alt_gnt_o` in [NPADS-1:0]; turnaround-in-progress flags in [NPADS+15:16].
  - 0x8 TURN: RW, bits [3:0], reset `TURN_CYCLES`.
  - 0xC reads 0; writes to it are ignored.
- Writes honour `wbs_sel_i` per byte. Unused bits read 0.

## Timing
- Reset (synchronous, applied at a clock edge):
  - All FSMs to GPIO, counters 0, `alt_gnt_o = 0`, `wbs_ack_o = 0`, `wbs_dat_o = 0`, registers to their reset values.
  - Therefore `pad_oeb_o = ~gpio_oe_i` immediately after reset.
- Reset mid-transfer or mid-turnaround drops the grant within the same edge. There is no turnaround on reset.
- Grant latency: with `alt_req_i` first high before edge k, TURN_A is entered at edge k and `alt_gnt_o` rises at edge k+TURN. The pad is tristated for exactly TURN cycles.
- Release latency:
  - `alt_gnt_o` falls at the first edge that samples `alt_req_i` low.
  - GPIO drives again after TURN tristate cycles.
- LOCK write takes effect on the edge after `wbs_ack_o`. A pad in ALT releases through TURN_G, never skipping turnaround.
- Wishbone:
  - `wbs_ack_o` pulses for one cycle, on the edge after `stb & cyc` is sampled with ack low.
  - Read data is valid while ack is high. The write is performed on the ack edge.
  - Back-to-back accesses take a minimum of 2 cycles each.
- Simultaneous release and LOCK write on the same edge: a single TURN_G.

## Configuration
- `PAD_ARB_WB_EN` defined:
  - Wishbone ports and the LOCK/STATUS/TURN registers exist.
  - TURN is programmable.
- `PAD_ARB_WB_EN` undefined:
  - The Wishbone ports are removed.
  - LOCK is constant 0 and TURN is the constant `TURN_CYCLES`.
  - Arbitration behaviour is otherwise identical.

## Test plan
- Reset with `gpio_oe_i = 8'hFF`, `gpio_o_i = 8'hA5` -> `pad_oeb_o = 0`, `pad_out_o = 8'hA5`, `alt_gnt_o = 0`.
- TURN = 2, raise `alt_req_i[3]` before edge 10 -> pad 3 tristated for edges 10..11, `alt_gnt_o[3]` rises at edge 12, `pad_out_o[3]` follows `alt_o[3]`; other pads unaffected.
- Drop `alt_req_i[3]` in ALT -> grant low at the next edge, pad 3 tristated for 2 cycles, then back to GPIO drive.
- Pulse `alt_req_i[5]` for 1 cycle with TURN = 4 -> abort: 1 cycle in TURN_A, back to GPIO, grant never asserted.
- `PAD_ARB_WB_EN`: write LOCK = 0x08 while pad 3 is in ALT -> release through TURN_G; a held request is not re-granted; STATUS reads `gnt = 0`.
- `PAD_ARB_WB_EN`: write TURN = 0 -> turnaround of 1 cycle. Read 0xC -> 0. Each ack lasts exactly 1 cycle.

Source files
------------

// File: rtl/azadi_pad_arbiter.sv
// Per-pad ownership arbiter between GPIO and one alternate function, with a tristated turnaround gap.
// Define PAD_ARB_WB_EN to add the Wishbone LOCK/STATUS/TURN registers; otherwise LOCK=0 and TURN=TURN_CYCLES.
module azadi_pad_arbiter #(
    parameter int NPADS       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NPADS-1:0] alt_req_i,
    output logic [NPADS-1:0] alt_gnt_o,
    input  logic [NPADS-1:0] alt_o,
    input  logic [NPADS-1:0] alt_oe_i,
    input  logic [NPADS-1:0] gpio_o_i,
    input  logic [NPADS-1:0] gpio_oe_i,
    input  logic [NPADS-1:0] pad_in_i,
    output logic [NPADS-1:0] pad_out_o,
    output logic [NPADS-1:0] pad_oeb_o,
    output logic [NPADS-1:0] gpio_i_o,
    output logic [NPADS-1:0] alt_i_o
`ifdef PAD_ARB_WB_EN
    ,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o
`endif
);

    typedef enum logic [1:0] {
        ST_GPIO   = 2'd0,
        ST_TURN_A = 2'd1,
        ST_ALT    = 2'd2,
        ST_TURN_G = 2'd3
    } pad_state_e;

    pad_state_e       state_r     [NPADS];
    pad_state_e       state_nxt_s [NPADS];
    logic [3:0]       cnt_r       [NPADS];
    logic [3:0]       cnt_nxt_s   [NPADS];
    logic [NPADS-1:0] gnt_r;
    logic [NPADS-1:0] tflag_s;
    logic [NPADS-1:0] lock_s;
    logic [3:0]       turn_s;
    logic [3:0]       turn_eff_s;

`ifdef PAD_ARB_WB_EN
    logic [NPADS-1:0] lock_r;
    logic [3:0]       turn_r;
    logic             ack_r;
    logic [31:0]      dat_r;
    logic [31:0]      rd_data_s;
    logic             access_s;
    logic             unused_wb_s;

    assign lock_s      = lock_r;
    assign turn_s      = turn_r;
    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = dat_r;
    assign access_s    = wbs_stb_i && wbs_cyc_i && !ack_r;
    assign unused_wb_s = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

    // Register read mux; unused bits read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0: rd_data_s[NPADS-1:0] = lock_r;
            2'd1: begin
                rd_data_s[NPADS-1:0]     = gnt_r;
                rd_data_s[NPADS+15:16]   = tflag_s;
            end
            2'd2: rd_data_s[3:0] = turn_r;
            default: rd_data_s = 32'd0;
        endcase
    end

    // Single-cycle ack; writes and read capture happen on the edge that raises ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lock_r <= '0;
            turn_r <= 4'(TURN_CYCLES);
            ack_r  <= 1'b0;
            dat_r  <= 32'd0;
        end else begin
            ack_r <= access_s;
            dat_r <= 32'd0;
            if (access_s) begin
                if (wbs_we_i) begin
                    case (wbs_adr_i[3:2])
                        2'd0: begin
                            for (int b = 0; b < NPADS; b++) begin
                                if (wbs_sel_i[b/8]) lock_r[b] <= wbs_dat_i[b];
                            end
                        end
                        2'd2: if (wbs_sel_i[0]) turn_r <= wbs_dat_i[3:0];
                        default: ;
                    endcase
                end else begin
                    dat_r <= rd_data_s;
                end
            end
        end
    end
`else
    assign lock_s = '0;
    assign turn_s = 4'(TURN_CYCLES);
`endif

    // A programmed turnaround of zero still tristates for one cycle.
    assign turn_eff_s = (turn_s == 4'd0) ? 4'd1 : turn_s;

    // Per-pad next state, turnaround counter and pad output mux.
    always_comb begin
        pad_out_o = '0;
        pad_oeb_o = '1;
        tflag_s   = '0;
        for (int i = 0; i < NPADS; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_GPIO: begin
                    pad_out_o[i] = gpio_o_i[i];
                    pad_oeb_o[i] = ~gpio_oe_i[i];
                    if (alt_req_i[i] && !lock_s[i]) begin
                        state_nxt_s[i] = ST_TURN_A;
                        cnt_nxt_s[i]   = turn_eff_s;
                    end else begin
                        state_nxt_s[i] = ST_GPIO;
                    end
                end
                ST_TURN_A: begin
                    tflag_s[i] = 1'b1;
                    if (!alt_req_i[i] || lock_s[i]) begin
                        state_nxt_s[i] = ST_GPIO;
                        cnt_nxt_s[i]   = 4'd0;
                    end else if (cnt_r[i] <= 4'd1) begin
                        state_nxt_s[i] = ST_ALT;
                        cnt_nxt_s[i]   = 4'd0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - 4'd1;
                    end
                end
                ST_ALT: begin
                    pad_out_o[i] = alt_o[i];
                    pad_oeb_o[i] = ~alt_oe_i[i];
                    if (!alt_req_i[i] || lock_s[i]) begin
                        state_nxt_s[i] = ST_TURN_G;
                        cnt_nxt_s[i]   = turn_eff_s;
                    end else begin
                        state_nxt_s[i] = ST_ALT;
                    end
                end
                ST_TURN_G: begin
                    tflag_s[i] = 1'b1;
                    if (cnt_r[i] <= 4'd1) begin
                        state_nxt_s[i] = ST_GPIO;
                        cnt_nxt_s[i]   = 4'd0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_GPIO;
                    cnt_nxt_s[i]   = 4'd0;
                end
            endcase
        end
    end

    // State, counter and grant registers; grant tracks the ALT state it is entering.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gnt_r <= '0;
            for (int i = 0; i < NPADS; i++) begin
                state_r[i] <= ST_GPIO;
                cnt_r[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NPADS; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
                gnt_r[i]   <= (state_nxt_s[i] == ST_ALT);
            end
        end
    end

    assign alt_gnt_o = gnt_r;
    assign gpio_i_o  = pad_in_i;
    assign alt_i_o   = pad_in_i & gnt_r;

endmodule

// File: tb/tb_azadi_pad_arbiter.sv
// Scoreboard bench for azadi_pad_arbiter: a behavioural pad model queues the expected outputs
// for each cycle as stimulus is applied; they are compared one edge later.
module tb_azadi_pad_arbiter;
    localparam int NP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req, gnt, alt_o, alt_oe, gpio_o, gpio_oe, pad_in;
    logic [NP-1:0] pad_out, pad_oeb, gpio_i, alt_i;
    logic          stb, cyc, we, ack;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat, rdat;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [NP-1:0] gnt, pout, poeb, gi, ai;
        logic          ack;
        logic [31:0]   dat;
    } exp_t;
    exp_t exp_q[$];

    // Model: mode 0 GPIO, 1 TURN_A, 2 ALT, 3 TURN_G; left = tristate cycles remaining.
    int            m_mode [NP];
    int            m_left [NP];
    logic [NP-1:0] m_lock;
    logic [3:0]    m_turn;
    logic          m_ack;
    logic [31:0]   m_dat;

    always #5 clk = ~clk;

    azadi_pad_arbiter #(.NPADS(NP), .TURN_CYCLES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .alt_req_i(req),
        .alt_gnt_o(gnt),
        .alt_o    (alt_o),
        .alt_oe_i (alt_oe),
        .gpio_o_i (gpio_o),
        .gpio_oe_i(gpio_oe),
        .pad_in_i (pad_in),
        .pad_out_o(pad_out),
        .pad_oeb_o(pad_oeb),
        .gpio_i_o (gpio_i),
        .alt_i_o  (alt_i)
`ifdef PAD_ARB_WB_EN
        ,
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat)
`endif
    );

`ifndef PAD_ARB_WB_EN
    assign ack  = 1'b0;
    assign rdat = 32'd0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance the model across the next edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] rd;
        int          teff;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_mode[i] = 0;
                m_left[i] = 0;
            end
            m_lock = '0;
            m_turn = 4'd2;
            m_ack  = 1'b0;
            m_dat  = 32'd0;
        end else begin
            rd = 32'd0;
            case (adr[3:2])
                2'd0: rd[NP-1:0] = m_lock;
                2'd1: for (int i = 0; i < NP; i++) begin
                    rd[i]      = (m_mode[i] == 2);
                    rd[16 + i] = (m_mode[i] == 1) || (m_mode[i] == 3);
                end
                2'd2: rd[3:0] = m_turn;
                default: rd = 32'd0;
            endcase
            teff = (m_turn == 4'd0) ? 1 : int'(m_turn);
            for (int i = 0; i < NP; i++) begin
                case (m_mode[i])
                    0: if (req[i] && !m_lock[i]) begin m_mode[i] = 1; m_left[i] = teff; end
                    1: if (!req[i] || m_lock[i]) m_mode[i] = 0;
                       else begin
                           m_left[i]--;
                           if (m_left[i] == 0) m_mode[i] = 2;
                       end
                    2: if (!req[i] || m_lock[i]) begin m_mode[i] = 3; m_left[i] = teff; end
                    default: begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_mode[i] = 0;
                    end
                endcase
            end
            m_dat = 32'd0;
            if (stb && cyc && !m_ack) begin
                m_ack = 1'b1;
                if (we) begin
                    if (adr[3:2] == 2'd0) begin
                        for (int b = 0; b < NP; b++) if (sel[b/8]) m_lock[b] = wdat[b];
                    end
                    if (adr[3:2] == 2'd2 && sel[0]) m_turn = wdat[3:0];
                end else begin
                    m_dat = rd;
                end
            end else begin
                m_ack = 1'b0;
            end
        end
    endtask

    // One clock: predict, queue, cross the edge, then compare what the DUT shows.
    task automatic cycle();
        exp_t e;
        model_step();
        for (int i = 0; i < NP; i++) begin
            e.gnt[i]  = (m_mode[i] == 2);
            e.pout[i] = (m_mode[i] == 0) ? gpio_o[i] : (m_mode[i] == 2) ? alt_o[i] : 1'b0;
            e.poeb[i] = (m_mode[i] == 0) ? ~gpio_oe[i] : (m_mode[i] == 2) ? ~alt_oe[i] : 1'b1;
        end
        e.gi  = pad_in;
        e.ai  = pad_in & e.gnt;
        e.ack = m_ack;
        e.dat = m_dat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("gnt", 32'(gnt), 32'(e.gnt));
        check_eq("pad_out", 32'(pad_out), 32'(e.pout));
        check_eq("pad_oeb", 32'(pad_oeb), 32'(e.poeb));
        check_eq("gpio_i", 32'(gpio_i), 32'(e.gi));
        check_eq("alt_i", 32'(alt_i), 32'(e.ai));
`ifdef PAD_ARB_WB_EN
        check_eq("ack", 32'(ack), 32'(e.ack));
        check_eq("rdat", rdat, e.dat);
`endif
    endtask

    task automatic wb_start(input logic w, input logic [31:0] a, input logic [31:0] d);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
    endtask

    task automatic wb_stop();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; alt_o = 8'h3C; alt_oe = 8'hF0;
        gpio_o = 8'hA5; gpio_oe = 8'hFF; pad_in = 8'h5A;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
        cycle();
        cycle();
        check_eq("rst_oeb", 32'(pad_oeb), 32'h00);
        check_eq("rst_out", 32'(pad_out), 32'hA5);
        check_eq("rst_gnt", 32'(gnt), 32'h00);
        rst = 1'b0;
        cycle();

        // Grant with TURN=2: two tristate cycles, then alt drives pad 3.
        alt_o = 8'hFF; alt_oe = 8'hFF; gpio_oe = 8'hFF; gpio_o = 8'h00;
        req[3] = 1'b1;
        cycle();
        check_eq("turn_a1_oeb3", 32'(pad_oeb[3]), 32'd1);
        cycle();
        check_eq("turn_a2_gnt3", 32'(gnt[3]), 32'd0);
        cycle();
        check_eq("gnt3_rise", 32'(gnt), 32'h08);
        check_eq("alt3_drive", 32'(pad_out[3]), 32'd1);
        check_eq("others_gpio", 32'(pad_out & 8'hF7), 32'h00);

        // Release: grant drops immediately, two tristate cycles, then GPIO.
        req[3] = 1'b0;
        cycle();
        check_eq("rel_gnt3", 32'(gnt[3]), 32'd0);
        check_eq("rel_oeb3", 32'(pad_oeb[3]), 32'd1);
        cycle();
        cycle();
        check_eq("rel_gpio3", 32'(pad_oeb[3]), 32'd0);

        // One-cycle request on pad 5 aborts from TURN_A.
        req[5] = 1'b1;
        cycle();
        req[5] = 1'b0;
        cycle();
        check_eq("abort_oeb5", 32'(pad_oeb[5]), 32'd0);
        for (int k = 0; k < 4; k++) cycle();

        // Reset while granted drops the grant on that edge.
        req[1] = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        rst = 1'b1;
        cycle();
        check_eq("rst_mid_gnt", 32'(gnt), 32'h00);
        rst = 1'b0; req = '0;
        cycle();

`ifdef PAD_ARB_WB_EN
        // LOCK pad 3 while in ALT: release through TURN_G, held request not re-granted.
        req[3] = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        wb_start(1'b1, 32'h0, 32'h08);
        cycle();
        check_eq("lock_ack", 32'(ack), 32'd1);
        wb_stop();
        cycle();
        check_eq("lock_gnt3", 32'(gnt[3]), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        wb_start(1'b0, 32'h4, 32'h0);
        cycle();
        check_eq("status_gnt", rdat & 32'h0000_00FF, 32'h0);
        wb_stop();
        cycle();
        wb_start(1'b1, 32'h0, 32'h0);
        cycle();
        wb_stop();
        // TURN = 0 behaves as a one-cycle turnaround.
        req[3] = 1'b0;
        wb_start(1'b1, 32'h8, 32'h0);
        cycle();
        wb_stop();
        cycle();
        req[2] = 1'b1;
        cycle();
        cycle();
        check_eq("turn0_gnt2", 32'(gnt[2]), 32'd1);
        // Held strobe: ack pulses one cycle, then again; 0xC reads zero.
        wb_start(1'b0, 32'hC, 32'h0);
        cycle();
        check_eq("c_read", rdat, 32'h0);
        cycle();
        check_eq("ack_pulse", 32'(ack), 32'd0);
        cycle();
        wb_stop();
        cycle();
        req = '0;
        for (int k = 0; k < 3; k++) cycle();
`endif

        // Random traffic with sticky requests and randomised pad data.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NP; i++) if ($urandom_range(7, 0) == 0) req[i] = ~req[i];
            alt_o   = 8'($urandom);
            alt_oe  = 8'($urandom);
            gpio_o  = 8'($urandom);
            gpio_oe = 8'($urandom);
            pad_in  = 8'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
